// File: rtl/cdr_pkg.sv
// Shared types and defaults for the CDR frame synchroniser.
// Imported by the FSM and its helper blocks.
package cdr_pkg;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } fs_state_t;

    localparam logic [7:0] CDR_SYNC_WORD   = 8'hA5;
    localparam int         CDR_PAYLOAD_LEN = 4;

endpackage

// File: rtl/sat_counter.sv
// 8-bit saturating increment counter with synchronous clear.
// Holds at 8'hFF once reached until cleared.
module sat_counter (
    input  logic       clk,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [7:0] o_cnt
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= 8'h00;
        end else if (i_inc && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cdr_frame_sync.sv
// Frame synchroniser / deserialiser behind the CDR core.
// Hunts for the sync byte, verifies, locks and emits payload bytes.
module cdr_frame_sync
    import cdr_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD   = CDR_SYNC_WORD,
    parameter int         PAYLOAD_LEN = CDR_PAYLOAD_LEN,
    parameter int         LOCK_CNT    = 3,
    parameter int         UNLOCK_CNT  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] sync_err
);

    localparam logic [2:0] LC = 3'(LOCK_CNT);
    localparam logic [2:0] UC = 3'(UNLOCK_CNT);
    localparam logic [3:0] PL = 4'(PAYLOAD_LEN);

    fs_state_t  r_state;
    fs_state_t  w_state_nxt;
    logic [7:0] r_sr;
    logic [2:0] r_bcnt;
    logic [3:0] r_bycnt;
    logic [2:0] r_good;
    logic [2:0] r_miss;
    logic [7:0] r_byte_out;
    logic       r_byte_valid;
    logic       r_frame_start;
    logic       r_locked;

    logic [7:0] w_sr;
    logic       w_match;
    logic       w_byte_done;
    logic       w_bnd;
    logic [2:0] w_good_inc;
    logic [2:0] w_miss_inc;
    logic [3:0] w_bycnt_adv;
    logic [2:0] w_bcnt_nxt;
    logic [3:0] w_bycnt_nxt;
    logic [2:0] w_good_nxt;
    logic [2:0] w_miss_nxt;
    logic [7:0] w_byte_nxt;
    logic       w_bv_nxt;
    logic       w_fs_nxt;
    logic       w_err_inc;

    assign w_sr        = {r_sr[6:0], bit_in};
    assign w_match     = (w_sr == SYNC_WORD);
    assign w_byte_done = (r_bcnt == 3'd7);
    assign w_bnd       = w_byte_done && (r_bycnt == 4'd0);
    assign w_good_inc  = r_good + 3'd1;
    assign w_miss_inc  = r_miss + 3'd1;
    assign w_bycnt_adv = (r_bycnt == PL) ? 4'd0 : r_bycnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_bycnt_nxt = r_bycnt;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_byte_nxt  = r_byte_out;
        w_bv_nxt    = 1'b0;
        w_fs_nxt    = 1'b0;
        w_err_inc   = 1'b0;
        if (bit_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (w_match) begin
                        w_state_nxt = (LC == 3'd1) ? LOCKED : VERIFY;
                        w_bcnt_nxt  = 3'd0;
                        w_bycnt_nxt = 4'd1;
                        w_good_nxt  = 3'd1;
                        w_miss_nxt  = 3'd0;
                    end
                end
                VERIFY: begin
                    w_bcnt_nxt = r_bcnt + 3'd1;
                    if (w_byte_done) w_bycnt_nxt = w_bycnt_adv;
                    if (w_bnd && w_match) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == LC) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = 3'd0;
                        end
                    end else if (w_bnd) begin
                        w_state_nxt = HUNT;
                        w_bcnt_nxt  = 3'd0;
                        w_bycnt_nxt = 4'd0;
                        w_good_nxt  = 3'd0;
                    end
                end
                LOCKED: begin
                    w_bcnt_nxt = r_bcnt + 3'd1;
                    if (w_byte_done) w_bycnt_nxt = w_bycnt_adv;
                    if (w_byte_done && (r_bycnt != 4'd0)) begin
                        w_bv_nxt   = 1'b1;
                        w_byte_nxt = w_sr;
                    end
                    if (w_bnd && w_match) begin
                        w_fs_nxt   = 1'b1;
                        w_miss_nxt = 3'd0;
                    end else if (w_bnd) begin
                        // alignment is trusted until the miss budget runs out
                        w_err_inc  = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == UC) begin
                            w_state_nxt = HUNT;
                            w_bcnt_nxt  = 3'd0;
                            w_bycnt_nxt = 4'd0;
                            w_good_nxt  = 3'd0;
                            w_miss_nxt  = 3'd0;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= HUNT;
            r_sr          <= 8'h00;
            r_bcnt        <= 3'd0;
            r_bycnt       <= 4'd0;
            r_good        <= 3'd0;
            r_miss        <= 3'd0;
            r_byte_out    <= 8'h00;
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sr          <= bit_valid ? w_sr : r_sr;
            r_bcnt        <= w_bcnt_nxt;
            r_bycnt       <= w_bycnt_nxt;
            r_good        <= w_good_nxt;
            r_miss        <= w_miss_nxt;
            r_byte_out    <= w_byte_nxt;
            r_byte_valid  <= w_bv_nxt;
            r_frame_start <= w_fs_nxt;
            r_locked      <= (w_state_nxt == LOCKED);
        end
    end

    sat_counter u_sync_err (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_err_inc),
        .o_cnt (sync_err)
    );

    assign byte_out    = r_byte_out;
    assign byte_valid  = r_byte_valid;
    assign frame_start = r_frame_start;
    assign locked      = r_locked;

endmodule

// File: tb/tb_cdr_frame_sync.sv
// Scoreboard bench for cdr_frame_sync: acquisition, false sync,
// miss tolerance, back-to-back bits, reset and error saturation.
`timescale 1ns/1ps
module tb_cdr_frame_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_start;
    logic       locked;
    logic [7:0] sync_err;
    logic [7:0] b_byte_out;
    logic       b_byte_valid;
    logic       b_frame_start;
    logic       b_locked;
    logic [7:0] b_sync_err;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_rx     = 0;
    int n_fs     = 0;
    logic prev_bv = 1'b0;

    always #10 clk = ~clk;

    cdr_frame_sync u_dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    cdr_frame_sync #(.UNLOCK_CNT(7)) u_dut7 (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .byte_out    (b_byte_out),
        .byte_valid  (b_byte_valid),
        .frame_start (b_frame_start),
        .locked      (b_locked),
        .sync_err    (b_sync_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (byte_valid) begin
            n_rx++;
            if (exp_q.size() == 0) begin
                chk("byte_unexpected", {24'h0, byte_out}, 32'hFFFF_FFFF);
            end else begin
                chk("byte_out", {24'h0, byte_out}, {24'h0, exp_q.pop_front()});
            end
            if (prev_bv) chk("bv_width", 32'd2, 32'd1);
        end
        if (frame_start) n_fs++;
        prev_bv <= byte_valid;
    end

    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        if (gap > 1) begin
            @(negedge clk);
            bit_valid = 1'b0;
            repeat (gap - 2) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
    endtask

    task automatic push_pl(input logic [31:0] pl);
        for (int i = 0; i < 4; i++) exp_q.push_back(pl[31-8*i -: 8]);
    endtask

    task automatic send_pl(input logic [31:0] pl, input int gap);
        for (int i = 0; i < 4; i++) send_byte(pl[31-8*i -: 8], gap);
    endtask

    task automatic send_frame(input logic [7:0] sync, input logic [31:0] pl,
                              input bit emit, input int gap);
        if (emit) push_pl(pl);
        send_byte(sync, gap);
        send_pl(pl, gap);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (n) begin
            @(negedge clk);
            bit_in    = 1'($urandom_range(0, 1));
            bit_valid = 1'($urandom_range(0, 1));
        end
        rst       = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_byte_out"}, {24'h0, byte_out}, 32'h0);
        chk({tag, "_byte_valid"}, {31'h0, byte_valid}, 32'h0);
        chk({tag, "_frame_start"}, {31'h0, frame_start}, 32'h0);
        chk({tag, "_locked"}, {31'h0, locked}, 32'h0);
        chk({tag, "_sync_err"}, {24'h0, sync_err}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] pre;
        logic [19:0] v;
        bit bad;
        int rx0, fs0;

        do_reset(3);
        chk_reset("por");

        // false sync: A5 inside data, wrong byte at the next boundary
        send_byte(8'h11, 2);
        send_byte(8'hA5, 2);
        send_pl(32'h22334455, 2);
        send_byte(8'h66, 2);
        idle(3);
        chk("false_locked", {31'h0, locked}, 32'h0);
        chk("false_rx", n_rx, 0);

        // clean acquisition, one bit every 4 cycles
        do_reset(2);
        do begin
            pre = 12'($urandom_range(0, 4095));
            v   = {pre, 8'hA5};
            bad = 1'b0;
            for (int k = 0; k < 12; k++)
                if (v[19-k -: 8] == 8'hA5) bad = 1'b1;
        end while (bad);
        for (int i = 11; i >= 0; i--) send_bit(pre[i], 4);
        fs0 = n_fs;
        send_frame(8'hA5, 32'h01020304, 1'b0, 4);
        chk("acq_f1_locked", {31'h0, locked}, 32'h0);
        send_frame(8'hA5, 32'h01020304, 1'b0, 4);
        chk("acq_f2_locked", {31'h0, locked}, 32'h0);
        push_pl(32'h01020304);
        send_byte(8'hA5, 4);
        chk("acq_f3_locked", {31'h0, locked}, 32'h1);
        chk("acq_f3_fs", n_fs - fs0, 0);
        send_pl(32'h01020304, 4);
        send_frame(8'hA5, 32'h01020304, 1'b1, 4);
        chk("acq_f4_fs", n_fs - fs0, 1);

        // miss tolerance
        push_pl(32'h01020304);
        send_byte(8'hA4, 4);
        chk("miss1_err", {24'h0, sync_err}, 32'd1);
        chk("miss1_locked", {31'h0, locked}, 32'h1);
        send_pl(32'h01020304, 4);
        send_frame(8'hA5, 32'h01020304, 1'b1, 4);
        chk("miss_recover_fs", n_fs - fs0, 2);
        push_pl(32'h01020304);
        send_byte(8'hA4, 4);
        chk("miss2a_locked", {31'h0, locked}, 32'h1);
        send_pl(32'h01020304, 4);
        send_byte(8'hA4, 4);
        chk("miss2b_locked", {31'h0, locked}, 32'h0);
        chk("miss2b_err", {24'h0, sync_err}, 32'd3);
        send_pl(32'h01020304, 4);
        idle(3);
        chk("acq_q_empty", exp_q.size(), 0);

        // back-to-back bits: relock then 10 frames
        rx0 = n_rx;
        fs0 = n_fs;
        send_frame(8'hA5, 32'h01020304, 1'b0, 1);
        send_frame(8'hA5, 32'h01020304, 1'b0, 1);
        send_frame(8'hA5, 32'h01020304, 1'b1, 1);
        for (int f = 0; f < 10; f++)
            send_frame(8'hA5, {8'(4*f+1), 8'(4*f+2), 8'(4*f+3), 8'(4*f+4)},
                       1'b1, 1);
        idle(3);
        chk("b2b_rx", n_rx - rx0, 44);
        chk("b2b_fs", n_fs - fs0, 10);
        chk("b2b_q_empty", exp_q.size(), 0);
        chk("b2b_locked", {31'h0, locked}, 32'h1);

        // reset mid-frame while locked
        push_pl(32'h05060000);
        send_byte(8'hA5, 1);
        send_byte(8'h05, 1);
        send_byte(8'h06, 1);
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        exp_q.delete();
        do_reset(3);
        chk_reset("mid");
        idle(1);
        chk_reset("mid_p1");
        send_frame(8'hA5, 32'h0A0B0C0D, 1'b0, 2);
        send_frame(8'hA5, 32'h0A0B0C0D, 1'b0, 2);
        idle(2);
        chk("relock_f2_locked", {31'h0, locked}, 32'h0);
        send_frame(8'hA5, 32'h0A0B0C0D, 1'b1, 2);
        idle(2);
        chk("relock_f3_locked", {31'h0, locked}, 32'h1);
        chk("relock_q_empty", exp_q.size(), 0);

        // saturation of the miss counter
        do_reset(2);
        for (int r = 1; r <= 43; r++) begin
            send_frame(8'hA5, 32'h01020304, 1'b0, 1);
            send_frame(8'hA5, 32'h01020304, 1'b0, 1);
            send_frame(8'hA5, 32'h01020304, 1'b1, 1);
            send_frame(8'h00, 32'h00000000, 1'b1, 1);
            for (int m = 0; m < 6; m++)
                send_frame(8'h00, 32'h00000000, 1'b0, 1);
            if (r == 36) begin
                idle(2);
                chk("sat_b_252", {24'h0, b_sync_err}, 32'd252);
            end
        end
        idle(3);
        chk("sat_b_255", {24'h0, b_sync_err}, 32'd255);
        chk("sat_a_86", {24'h0, sync_err}, 32'd86);
        chk("sat_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdr_frame_sync.md
# cdr_frame_sync

Frame synchroniser and deserialiser that sits directly downstream of the CDR core in `tt_um_sfg_cdr`. It consumes the recovered bit stream and its per-bit strobe, hunts for a fixed sync byte, confirms lock over several frame periods and emits payload bytes with a valid strobe. Repeated sync misses drop lock, and the block then re-hunts.

## Interface
Parameters:
- `SYNC_WORD`, default 8'hA5: sync byte, transmitted MSB first at the start of every frame.
- `PAYLOAD_LEN`, default 4: payload bytes per frame, range 1..15.
- `LOCK_CNT`, default 3: consecutive correct sync bytes needed to declare lock, range 1..7.
- `UNLOCK_CNT`, default 2: consecutive missed sync bytes needed to drop lock, range 1..7.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous reset, active-high.
- `bit_in` in 1: recovered data bit from the CDR. Sampled only when `bit_valid` is 1.
- `bit_valid` in 1: one-cycle strobe, one per recovered bit.
- `byte_out` out 8: payload byte, MSB = first received bit.
- `byte_valid` out 1: one-cycle strobe qualifying `byte_out`.
- `frame_start` out 1: one-cycle pulse when a sync byte is accepted while locked.
- `locked` out 1: high in state LOCKED.
- `sync_err` out 8: count of sync misses while locked; saturates at 255.

## Operation
- Shift register `sr[7:0]` takes a new bit only on `bit_valid`: `sr <= {sr[6:0], bit_in}`. With `bit_valid` low, all state, counters and `sr` hold.
- Bit counter `bcnt` runs 0..7. Byte counter `bycnt` runs 0..PAYLOAD_LEN; byte index 0 is the sync byte. Both advance only on `bit_valid`.
- "Boundary" means the `bit_valid` cycle that completes byte index 0. In that cycle, "match" means the post-shift value equals `SYNC_WORD`.
- States:
  - HUNT: compare the post-shift value on every valid bit. On match go to VERIFY, clear `bcnt` and set `bycnt` to 1, and set the good counter to 1. If `LOCK_CNT` is 1, go straight to LOCKED instead.
  - VERIFY: count through the frame. At each boundary, a match increments the good counter; reaching `LOCK_CNT` enters LOCKED. A mismatch returns to HUNT with counters cleared. No `byte_valid` is emitted in VERIFY.
  - LOCKED: each completed payload byte (index 1..PAYLOAD_LEN) drives `byte_out` = post-shift `sr` and pulses `byte_valid`.
    - At a boundary, a match pulses `frame_start` and clears the miss counter.
    - At a boundary, a mismatch increments `sync_err` (saturating) and the miss counter. Alignment is kept.
    - The miss counter reaching `UNLOCK_CNT` goes to HUNT. The payload bytes of a frame whose sync byte was missed are still emitted.
- `sync_err` clears only on `rst`. It holds across lock loss.

## Timing
- Reset values: `byte_out` 8'h00, `byte_valid` 0, `frame_start` 0, `locked` 0, `sync_err` 0, state HUNT, `sr` 8'h00, all counters 0.
- `rst` has priority over everything in the same cycle. Reset mid-frame discards the partial byte.
- Latency: `byte_valid` and `frame_start` are registered and assert in the cycle after the `bit_valid` cycle that completed the byte. Both are high for exactly one cycle.
- `locked` rises in the cycle after the accepting boundary. It falls in the cycle after the boundary that hits `UNLOCK_CNT`. The first `byte_valid` follows the next completed payload byte.
- Back-to-back `bit_valid` (every cycle) must be supported without loss.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `cdr_pkg`:
  - state enum `fs_state_t` with values HUNT, VERIFY, LOCKED;
  - default constants `CDR_SYNC_WORD` and `CDR_PAYLOAD_LEN`.
- A single sub-module is natural: `sat_counter`, an 8-bit saturating increment counter with synchronous clear, used for `sync_err`.
- Everything else is one FSM module. The top `tt_um_sfg_cdr` drives `rst` = `~rst_n`, registered in its own always block.

## Test plan
- Reset: hold `rst` for 3 cycles mid-stream. All outputs read their reset values on the cycle after; `locked` stays 0 until a fresh `LOCK_CNT` frames have arrived.
- Clean acquisition:
  - stimulus: 12 random bits, then 4 frames of A5 01 02 03 04, one bit every 4 cycles;
  - `locked` rises after the 3rd sync;
  - then `byte_valid` pulses 4 times, with `byte_out` = 01, 02, 03, 04;
  - `frame_start` pulses at the 4th sync.
- False sync: a payload that contains A5, followed by a wrong byte at the expected boundary. The block returns to HUNT, never locks, and `byte_valid` is never asserted.
- Miss tolerance while locked:
  - one corrupted sync (A4): `sync_err` = 1, `locked` stays 1, and that frame's payload is still emitted;
  - two consecutive corrupted syncs: `locked` = 0 and `sync_err` = 3.
- Continuous `bit_valid` at every cycle for 10 frames: all 40 payload bytes are received in order, with no gaps or duplicates.
- Saturation: 300 missed syncs with `UNLOCK_CNT` raised to 7 and lock re-acquired in between. `sync_err` stops at 255.
